// File: rtl/hazard_unit_sb_pkg.sv
// Shared types for the hazard unit: forwarding mux selects and MDU tracker states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10,
        FWD_SRC = 2'b11
    } fwdSel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } mduState_t;

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Datapath <-> hazard unit bundle; master is the datapath, slave is the hazard unit.
interface hazard_unit_sb_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] Rs1D, Rs2D, RdD;
    logic                  UseRs1D, UseRs2D, RegWriteD, MduOpD;
    logic [REG_ADDR_W-1:0] Rs1E, Rs2E, RdE;
    logic                  PCSrcE, ResultSrcE_zero, SrcAsrcE, ALUSrcE, MduStartE;
    logic [REG_ADDR_W-1:0] RdM, RdW;
    logic                  RegWriteM, RegWriteW, MduDone;

    logic                  MduAck, StallF, StallD, FlushD, FlushE, MduTimeout;
    logic [1:0]            ForwardAE, ForwardBE;
    logic [CNT_W-1:0]      StallCnt, FlushCnt;

    modport master (
        output Rs1D, Rs2D, RdD, UseRs1D, UseRs2D, RegWriteD, MduOpD,
               Rs1E, Rs2E, RdE, PCSrcE, ResultSrcE_zero, SrcAsrcE, ALUSrcE, MduStartE,
               RdM, RdW, RegWriteM, RegWriteW, MduDone,
        input  MduAck, StallF, StallD, FlushD, FlushE, MduTimeout,
               ForwardAE, ForwardBE, StallCnt, FlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, UseRs1D, UseRs2D, RegWriteD, MduOpD,
               Rs1E, Rs2E, RdE, PCSrcE, ResultSrcE_zero, SrcAsrcE, ALUSrcE, MduStartE,
               RdM, RdW, RegWriteM, RegWriteW, MduDone,
        output MduAck, StallF, StallD, FlushD, FlushE, MduTimeout,
               ForwardAE, ForwardBE, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_unit_sb_mdu_scoreboard.sv
// Tracks the single outstanding MDU op: pending-register bits, issue/writeback FSM,
// latency watchdog and write-port arbitration against the W stage.
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_MAX_LAT = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MduStartE,
    input  logic [REG_ADDR_W-1:0]      RdE,
    input  logic                       MduDone,
    input  logic                       RegWriteW,
    output logic [2**REG_ADDR_W-1:0]   pend,
    output logic                       mduIdle,
    output logic                       MduAck,
    output logic                       MduTimeout
);
    localparam int                WD_W     = $clog2(MDU_MAX_LAT + 1);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(MDU_MAX_LAT);

    mduState_t             state;
    logic [REG_ADDR_W-1:0] pendRd;
    logic [WD_W-1:0]       wdCnt;
    logic [WD_W-1:0]       wdNext;

    assign wdNext  = wdCnt + 1'b1;
    assign mduIdle = (state == IDLE);
    // The W stage owns the register-file write port; the MDU only gets it when W is idle.
    assign MduAck  = (state == WB) && MduDone && !RegWriteW && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend       <= '0;
            state      <= IDLE;
            pendRd     <= '0;
            wdCnt      <= '0;
            MduTimeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (MduStartE) begin
                    state  <= BUSY;
                    pendRd <= RdE;
                    wdCnt  <= '0;
                end
                BUSY: if (MduDone) begin
                    state <= WB;
                end else if (wdNext == WD_LIMIT) begin
                    MduTimeout   <= 1'b1;
                    pend[pendRd] <= 1'b0;
                    state        <= IDLE;
                end else begin
                    wdCnt <= wdNext;
                end
                WB: if (MduAck) begin
                    pend[pendRd] <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Issue is written last so a new op's pending bit survives a same-cycle clear.
            if (MduStartE && RdE != '0)
                pend[RdE] <= 1'b1;
        end
    end
endmodule

// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit: M/W forwarding, load-use and MDU-scoreboard stalls, branch flushes,
// saturating stall/flush counters. Forwarding/stall paths are combinational.
module hazard_unit_sb
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_MAX_LAT = 40,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    hazard_unit_sb_if.slave  hif
);
    localparam int NUM_REGS = 2**REG_ADDR_W;

    logic [NUM_REGS-1:0] pend;
    logic                mduIdle;
    logic                src1, src2, lwStall, mduStall, stall;
    logic [CNT_W-1:0]    stallCnt, flushCnt;

    function automatic fwdSel_t fwdSel(
        input logic                  useSrc,
        input logic [REG_ADDR_W-1:0] rsE,
        input logic [REG_ADDR_W-1:0] rdM,
        input logic                  wrM,
        input logic [REG_ADDR_W-1:0] rdW,
        input logic                  wrW
    );
        if (useSrc)                              return FWD_SRC;
        else if (wrM && rsE == rdM && rsE != '0) return FWD_M;
        else if (wrW && rsE == rdW && rsE != '0) return FWD_W;
        else                                     return FWD_RF;
    endfunction

    mdu_scoreboard #(
        .REG_ADDR_W  (REG_ADDR_W),
        .MDU_MAX_LAT (MDU_MAX_LAT)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .MduStartE  (hif.MduStartE),
        .RdE        (hif.RdE),
        .MduDone    (hif.MduDone),
        .RegWriteW  (hif.RegWriteW),
        .pend       (pend),
        .mduIdle    (mduIdle),
        .MduAck     (hif.MduAck),
        .MduTimeout (hif.MduTimeout)
    );

    always_comb begin
        src1    = hif.UseRs1D && hif.Rs1D != '0;
        src2    = hif.UseRs2D && hif.Rs2D != '0;
        lwStall = hif.ResultSrcE_zero && hif.RdE != '0 &&
                  ((src1 && hif.Rs1D == hif.RdE) || (src2 && hif.Rs2D == hif.RdE));
        // The op issuing from E has not reached the scoreboard yet, so check it directly.
        mduStall = (src1 && pend[hif.Rs1D]) || (src2 && pend[hif.Rs2D]) ||
                   (hif.RegWriteD && hif.RdD != '0 && pend[hif.RdD]) ||
                   (hif.MduStartE && hif.RdE != '0 &&
                    ((src1 && hif.Rs1D == hif.RdE) || (src2 && hif.Rs2D == hif.RdE) ||
                     (hif.RegWriteD && hif.RdD == hif.RdE))) ||
                   (hif.MduOpD && (!mduIdle || hif.MduStartE));
        stall    = (lwStall || mduStall) && !hif.PCSrcE;
    end

    assign hif.StallF    = stall && !reset;
    assign hif.StallD    = stall && !reset;
    assign hif.FlushD    = hif.PCSrcE || reset;
    assign hif.FlushE    = stall || hif.PCSrcE || reset;
    assign hif.ForwardAE = reset ? FWD_RF : fwdSel(hif.SrcAsrcE, hif.Rs1E, hif.RdM, hif.RegWriteM, hif.RdW, hif.RegWriteW);
    assign hif.ForwardBE = reset ? FWD_RF : fwdSel(hif.ALUSrcE, hif.Rs2E, hif.RdM, hif.RegWriteM, hif.RdW, hif.RegWriteW);
    assign hif.StallCnt  = stallCnt;
    assign hif.FlushCnt  = flushCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stall && stallCnt != '1)
                stallCnt <= stallCnt + 1'b1;
            if (hif.PCSrcE && flushCnt != '1)
                flushCnt <= flushCnt + 1'b1;
        end
    end
endmodule
